// File: rtl/score_pkg.sv
// Shared scoring definitions: outcome codes, entry FSM and pending-class enums, over length.
// Latency: n/a (package only).
// Backpressure: n/a.
package score_pkg;

  localparam int BALLS_PER_OVER = 6;

  // Outcome codes, shared with the LFSR-driven score/wicket and ball-count decoders.
  localparam logic [3:0] OUT_DOT    = 4'd0;
  localparam logic [3:0] OUT_SINGLE = 4'd3;
  localparam logic [3:0] OUT_DOUBLE = 4'd7;
  localparam logic [3:0] OUT_TRIPLE = 4'd10;
  localparam logic [3:0] OUT_FOUR   = 4'd11;
  localparam logic [3:0] OUT_SIX    = 4'd12;
  localparam logic [3:0] OUT_EXTRA  = 4'd13;
  localparam logic [3:0] OUT_WICKET = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ISSUE
  } entry_state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_RUNS,
    CLS_WICKET,
    CLS_EXTRA
  } pend_class_t;

  // Maps a pending entry to its outcome code. Runs = 5 has no code; callers
  // reject it before issuing, so it falls through to a dot here.
  function automatic logic [3:0] encode_outcome(input pend_class_t cls,
                                                input logic [2:0]  runs);
    logic [3:0] code;
    code = OUT_DOT;
    case (cls)
      CLS_WICKET: code = OUT_WICKET;
      CLS_EXTRA:  code = OUT_EXTRA;
      default: begin
        case (runs)
          3'd1:    code = OUT_SINGLE;
          3'd2:    code = OUT_DOUBLE;
          3'd3:    code = OUT_TRIPLE;
          3'd4:    code = OUT_FOUR;
          3'd6:    code = OUT_SIX;
          default: code = OUT_DOT;
        endcase
      end
    endcase
    return code;
  endfunction

endpackage

// File: rtl/over_counter.sv
// Balls-in-over / completed-overs counter driven by a legal-ball increment.
// Latency: counters update on the clock edge that samples legal_ball.
// Backpressure: none; overs saturates at MAX_OVERS.
// Ports: clk, reset (async, active-high), legal_ball (1-cycle increment),
//        ball_in_over (0..BALLS_PER_OVER-1), overs (0..MAX_OVERS).
module over_counter
  import score_pkg::*;
#(
  parameter int MAX_OVERS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       legal_ball,
  output logic [2:0] ball_in_over,
  output logic [4:0] overs
);

  localparam logic [2:0] LAST_BALL = 3'(BALLS_PER_OVER - 1);
  localparam logic [4:0] OVER_MAX  = 5'(MAX_OVERS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_in_over <= 3'd0;
      overs        <= 5'd0;
    end else if (legal_ball) begin
      if (ball_in_over == LAST_BALL) begin
        ball_in_over <= 3'd0;
        if (overs != OVER_MAX) begin
          overs <= overs + 5'd1;
        end
      end else begin
        ball_in_over <= ball_in_over + 3'd1;
      end
    end
  end

endmodule

// File: rtl/delivery_entry_encoder.sv
// Manual umpire entry: collects button presses and issues one delivery strobe + outcome code.
// Latency: delivery/outcome/ball counters update 1 cycle after btn_confirm is sampled.
// Backpressure: presses during the ISSUE cycle are dropped; confirm refused while block is high.
// Ports: clk, reset (async, active-high); btn_run/btn_wicket/btn_extra/btn_confirm/btn_cancel
//        (1-cycle pulses), block (level); delivery, outcome, pending_runs, busy, err,
//        ball_in_over, overs.
// Optional: define DELIVERY_ENTRY_TIMEOUT_EN to discard an entry left idle for
//           TIMEOUT_CYCLES cycles in COLLECT.
module delivery_entry_encoder
  import score_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50,
  parameter int MAX_OVERS      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_wicket,
  input  logic       btn_extra,
  input  logic       btn_confirm,
  input  logic       btn_cancel,
  input  logic       block,
  output logic       delivery,
  output logic [3:0] outcome,
  output logic [2:0] pending_runs,
  output logic       busy,
  output logic       err,
  output logic [2:0] ball_in_over,
  output logic [4:0] overs
);

  if (TIMEOUT_CYCLES < 1 || MAX_OVERS < 1 || MAX_OVERS > 31) begin : g_bad_cfg
    $error("delivery_entry_encoder: TIMEOUT_CYCLES must be >= 1 and MAX_OVERS in 1..31");
  end

  entry_state_t state;
  pend_class_t  cls;

  logic accepting, reject_confirm;
  logic do_cancel, do_confirm, do_wicket, do_extra, do_run;
  logic run_ok, class_free, press_ok, press_bad;
  logic issue_go, legal_ball, timeout_hit;

  // One press acts per cycle: cancel > confirm > wicket > extra > run.
  always_comb begin
    accepting      = (state != ST_ISSUE);
    reject_confirm = block || (overs == 5'(MAX_OVERS)) || (pending_runs == 3'd5);

    do_cancel  = accepting && btn_cancel;
    do_confirm = accepting && !btn_cancel && btn_confirm;
    do_wicket  = accepting && !btn_cancel && !btn_confirm && btn_wicket;
    do_extra   = accepting && !btn_cancel && !btn_confirm && !btn_wicket && btn_extra;
    do_run     = accepting && !btn_cancel && !btn_confirm && !btn_wicket && !btn_extra
                 && btn_run;

    // In IDLE the class is always NONE and runs are 0, so every press is accepted there.
    class_free = (cls == CLS_NONE);
    run_ok     = ((cls == CLS_NONE) || (cls == CLS_RUNS)) && (pending_runs != 3'd6);

    press_ok  = (do_wicket && class_free) || (do_extra && class_free) || (do_run && run_ok);
    press_bad = (do_wicket && !class_free) || (do_extra && !class_free)
                || (do_run && !run_ok) || (do_confirm && reject_confirm);

    issue_go   = do_confirm && !reject_confirm;
    legal_ball = issue_go && (cls != CLS_EXTRA);
  end

`ifdef DELIVERY_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive COLLECT cycle without an accepted
  // press; cancel/confirm leave COLLECT on their own and take precedence.
  always_comb begin
    timeout_hit = (state == ST_COLLECT) && !do_cancel && !do_confirm && !press_ok
                  && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if ((state != ST_COLLECT) || press_ok || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cls          <= CLS_NONE;
      pending_runs <= 3'd0;
      delivery     <= 1'b0;
      outcome      <= OUT_DOT;
      err          <= 1'b0;
    end else begin
      delivery <= 1'b0;
      err      <= press_bad || timeout_hit;
      case (state)
        ST_ISSUE: begin
          state <= ST_IDLE;
        end
        default: begin
          if (do_cancel || do_confirm || timeout_hit) begin
            // Any exit from the entry discards the pending tally; a successful
            // confirm encodes what was registered before this cycle.
            cls          <= CLS_NONE;
            pending_runs <= 3'd0;
            state        <= ST_IDLE;
            if (issue_go) begin
              delivery <= 1'b1;
              outcome  <= encode_outcome(cls, pending_runs);
              state    <= ST_ISSUE;
            end
          end else if (press_ok) begin
            state <= ST_COLLECT;
            if (do_wicket) begin
              cls <= CLS_WICKET;
            end else if (do_extra) begin
              cls <= CLS_EXTRA;
            end else begin
              cls          <= CLS_RUNS;
              pending_runs <= pending_runs + 3'd1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    busy = (state == ST_COLLECT);
  end

  over_counter #(
    .MAX_OVERS(MAX_OVERS)
  ) u_over_counter (
    .clk         (clk),
    .reset       (reset),
    .legal_ball  (legal_ball),
    .ball_in_over(ball_in_over),
    .overs       (overs)
  );

endmodule

// File: tb/tb_delivery_entry_encoder.sv
// Scoreboard bench for delivery_entry_encoder: a press-level reference model predicts
// deliveries, err pulses and per-cycle status; a negedge monitor pops and compares.
module tb_delivery_entry_encoder;

  localparam int MAXO = 2;
  localparam int TMO  = 50;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_run = 0, btn_wicket = 0, btn_extra = 0, btn_confirm = 0, btn_cancel = 0;
  logic block = 0;
  logic       delivery, busy, err;
  logic [3:0] outcome;
  logic [2:0] pending_runs, ball_in_over;
  logic [4:0] overs;

  delivery_entry_encoder #(.TIMEOUT_CYCLES(TMO), .MAX_OVERS(MAXO)) dut (
    .clk(clk), .reset(reset),
    .btn_run(btn_run), .btn_wicket(btn_wicket), .btn_extra(btn_extra),
    .btn_confirm(btn_confirm), .btn_cancel(btn_cancel), .block(block),
    .delivery(delivery), .outcome(outcome), .pending_runs(pending_runs), .busy(busy),
    .err(err), .ball_in_over(ball_in_over), .overs(overs)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int stamp; int outc; int bio; int ov; } dlv_t;
  typedef struct { int stamp; int runs; int bsy; int outc; int bio; int ov; } st_t;
  dlv_t dq[$];
  int   eq[$];
  st_t  sq[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: an entry is a class (0 none, 1 runs, 2 wicket, 3 extra) plus a
  // run tally; the innings is just a count of legal balls.
  int run_code[7] = '{0, 3, 7, 10, 11, -1, 12};
  bit m_collect = 0, m_issue = 0;
  int m_cls = 0, m_runs = 0, m_legal = 0, m_out = 0, m_idle = 0;

  function automatic int m_overs();
    return (m_legal / 6 > MAXO) ? MAXO : m_legal / 6;
  endfunction

  function automatic st_t m_status(input int stamp);
    st_t s;
    s.stamp = stamp; s.runs = m_runs; s.bsy = int'(m_collect);
    s.outc = m_out; s.bio = m_legal % 6; s.ov = m_overs();
    return s;
  endfunction

  task automatic m_clear();
    m_collect = 0; m_cls = 0; m_runs = 0;
  endtask

  // Called at posedge+1: drives one cycle of buttons, predicts what the next edge produces.
  task automatic step(input bit run, input bit wk, input bit ex, input bit cf,
                      input bit cn, input bit blk);
    int stamp;
    bit err_e, acc;
    stamp = cyc + 1; err_e = 0; acc = 0;
    btn_run = run; btn_wicket = wk; btn_extra = ex; btn_confirm = cf; btn_cancel = cn;
    block = blk;
    if (m_issue) begin
      m_issue = 0;
    end else if (cn) begin
      m_clear();
    end else if (cf) begin
      if (blk || m_overs() >= MAXO || m_runs == 5) begin
        err_e = 1;
      end else begin
        m_out = (m_cls == 2) ? 15 : (m_cls == 3) ? 13 : run_code[m_runs];
        if (m_cls != 3) m_legal++;
        dq.push_back('{stamp, m_out, m_legal % 6, m_overs()});
        m_issue = 1;
      end
      m_clear();
    end else if (wk || ex) begin
      if (m_cls == 0) begin m_cls = wk ? 2 : 3; m_collect = 1; acc = 1; end
      else err_e = 1;
    end else if (run) begin
      if ((m_cls == 0 || m_cls == 1) && m_runs < 6) begin
        m_runs++; m_cls = 1; m_collect = 1; acc = 1;
      end else err_e = 1;
    end
`ifdef DELIVERY_ENTRY_TIMEOUT_EN
    if (m_collect && !acc) begin
      if (m_idle == TMO - 1) begin err_e = 1; m_clear(); m_idle = 0; end
      else m_idle++;
    end else m_idle = 0;
`endif
    if (err_e) eq.push_back(stamp);
    sq.push_back(m_status(stamp));
    @(posedge clk); #1;
    btn_run = 0; btn_wicket = 0; btn_extra = 0; btn_confirm = 0; btn_cancel = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted at posedge+1: the current cycle's predictions are void.
  task automatic do_reset();
    reset = 1;
    while (dq.size() > 0 && dq[$].stamp >= cyc) void'(dq.pop_back());
    while (eq.size() > 0 && eq[$] >= cyc) void'(eq.pop_back());
    while (sq.size() > 0 && sq[$].stamp >= cyc) void'(sq.pop_back());
    m_clear(); m_issue = 0; m_legal = 0; m_out = 0; m_idle = 0;
    sq.push_back(m_status(cyc));
    @(posedge clk); #1;
    sq.push_back(m_status(cyc));
    reset = 0;
  endtask

  // Monitor.
  always @(negedge clk) begin
    while (dq.size() > 0 && dq[0].stamp < cyc) begin
      chk("missing_delivery", 0, 1); void'(dq.pop_front());
    end
    if (delivery) begin
      if (dq.size() == 0 || dq[0].stamp != cyc) chk("unexpected_delivery", 1, 0);
      else begin
        dlv_t d;
        d = dq.pop_front();
        chk("dlv_outcome", int'(outcome), d.outc);
        chk("dlv_ball_in_over", int'(ball_in_over), d.bio);
        chk("dlv_overs", int'(overs), d.ov);
      end
    end
    while (eq.size() > 0 && eq[0] < cyc) begin
      chk("missing_err", 0, 1); void'(eq.pop_front());
    end
    if (err) begin
      if (eq.size() == 0 || eq[0] != cyc) chk("unexpected_err", 1, 0);
      else begin chk("err_cycle", cyc, eq[0]); void'(eq.pop_front()); end
    end
    while (sq.size() > 0 && sq[0].stamp < cyc) void'(sq.pop_front());
    if (sq.size() > 0 && sq[0].stamp == cyc) begin
      st_t s;
      s = sq.pop_front();
      chk("pending_runs", int'(pending_runs), s.runs);
      chk("busy", int'(busy), s.bsy);
      chk("outcome_held", int'(outcome), s.outc);
      chk("ball_in_over", int'(ball_in_over), s.bio);
      chk("overs", int'(overs), s.ov);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_delivery", int'(delivery), 0);
    chk("rst_outcome", int'(outcome), 0);
    chk("rst_pending_runs", int'(pending_runs), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ball_in_over", int'(ball_in_over), 0);
    chk("rst_overs", int'(overs), 0);
    reset = 0;
    idle(2);

    // run x2, confirm -> 7, first legal ball
    step(1,0,0,0,0,0); step(1,0,0,0,0,0); step(0,0,0,1,0,0); idle(3);
    // wicket then run -> err; confirm -> 15
    step(0,1,0,0,0,0); step(1,0,0,0,0,0); idle(1); step(0,0,0,1,0,0); idle(2);
    // extra -> 13, no ball counted
    step(0,0,1,0,0,0); step(0,0,0,1,0,0); idle(2);
    // six legal dots from ball 0
    do_reset();
    for (int i = 0; i < 6; i++) begin step(0,0,0,1,0,0); idle(1); end
    // run x5 confirm -> rejected; run x7 -> saturate with err, confirm -> 12
    for (int i = 0; i < 5; i++) step(1,0,0,0,0,0);
    step(0,0,0,1,0,0); idle(2);
    for (int i = 0; i < 7; i++) step(1,0,0,0,0,0);
    step(0,0,0,1,0,0); idle(2);
    // block refuses confirm; cancel beats confirm; presses in ISSUE dropped
    step(1,0,0,0,0,1); step(0,0,0,1,0,1); idle(2);
    step(1,0,0,0,0,0); step(0,0,0,1,1,0); idle(2);
    step(0,0,0,1,0,0); step(1,1,1,0,0,0); idle(2);
    // over limit: confirm refused once overs == MAXO
    for (int i = 0; i < 6 * MAXO + 2; i++) step(0,0,0,1,0,0);
    idle(2);
`ifdef DELIVERY_ENTRY_TIMEOUT_EN
    do_reset();
    step(1,0,0,0,0,0); idle(TMO + 2); step(0,0,0,1,0,0); idle(2);
`endif

    // Randomized stimulus with occasional mid-entry resets.
    begin
      bit blk;
      blk = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 299) == 0) do_reset();
        if ($urandom_range(0, 19) == 0) blk = ~blk;
        step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 23) == 0, blk);
      end
    end
    idle(4);
    chk("dq_drained", dq.size(), 0);
    chk("eq_drained", eq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
